// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the multiplexed BCD display scanner.
// Segment bit order: Seg[0]=a, Seg[1]=b, ... Seg[6]=g. All glyphs are active-high.
package bcd_disp_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned BCD_W = 4;

    // Segment bit positions within a 7-bit segment word
    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    typedef logic [SEG_W-1:0] seg_t;
    typedef logic [BCD_W-1:0] bcd_t;

    localparam seg_t SEG_0     = 7'h3F;  // a b c d e f
    localparam seg_t SEG_1     = 7'h06;  // b c
    localparam seg_t SEG_2     = 7'h5B;  // a b d e g
    localparam seg_t SEG_3     = 7'h4F;  // a b c d g
    localparam seg_t SEG_4     = 7'h66;  // b c f g
    localparam seg_t SEG_5     = 7'h6D;  // a c d f g
    localparam seg_t SEG_6     = 7'h7D;  // a c d e f g
    localparam seg_t SEG_7     = 7'h07;  // a b c
    localparam seg_t SEG_8     = 7'h7F;  // all
    localparam seg_t SEG_9     = 7'h6F;  // a b c d f g
    localparam seg_t SEG_DASH  = SEG_W'(1 << SEG_G);
    localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Bus between the BCD counter chain and the display scanner.
// master: counter side (drives Load/Bcd/Dp_In/Blank_Lz, observes display pins)
// slave : scanner side (drives Seg/Dp_Out/An/Frame)
interface bcd_display_scanner_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    import bcd_disp_pkg::*;

    logic                        Load;
    logic [BCD_W*NUM_DIGITS-1:0] Bcd;
    logic [NUM_DIGITS-1:0]       Dp_In;
    logic                        Blank_Lz;
    seg_t                        Seg;
    logic                        Dp_Out;
    logic [NUM_DIGITS-1:0]       An;
    logic                        Frame;

    modport master (
        output Load, Bcd, Dp_In, Blank_Lz,
        input  Seg, Dp_Out, An, Frame
    );

    modport slave (
        input  Load, Bcd, Dp_In, Blank_Lz,
        output Seg, Dp_Out, An, Frame
    );

endinterface

// File: rtl/bcd_seg_decode.sv
// Combinational BCD to 7-segment decoder (active-high segments).
// code  : 4-bit digit code; 10..15 render as a dash
// blank : forces all segments off
// seg_c : segments a..g on bits 0..6
module bcd_seg_decode
    import bcd_disp_pkg::*;
(
    input  bcd_t code,
    input  logic blank,
    output seg_t seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        if (!blank) begin
            case (code)
                4'd0:    seg_c = SEG_0;
                4'd1:    seg_c = SEG_1;
                4'd2:    seg_c = SEG_2;
                4'd3:    seg_c = SEG_3;
                4'd4:    seg_c = SEG_4;
                4'd5:    seg_c = SEG_5;
                4'd6:    seg_c = SEG_6;
                4'd7:    seg_c = SEG_7;
                4'd8:    seg_c = SEG_8;
                4'd9:    seg_c = SEG_9;
                default: seg_c = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed 7-segment display scanner with frame-aligned updates and
// leading-zero blanking.
// Clk, Rst : clock, asynchronous active-high reset
// bus      : Load/Bcd/Dp_In/Blank_Lz in; Seg/Dp_Out/An/Frame out (all registered)
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    bcd_display_scanner_if.slave    bus
);

    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DATA_W = BCD_W * NUM_DIGITS;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    // XOR masks that also serve as the inactive output levels
    localparam seg_t                  SEG_INV = {SEG_W{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_INV  = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic                  DP_INV  = ACTIVE_LOW;

    logic [PRE_W-1:0]      pre_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_W-1:0]     shadow_bcd_q;
    logic [NUM_DIGITS-1:0] shadow_dp_q;
    logic [DATA_W-1:0]     disp_bcd_q;
    logic [NUM_DIGITS-1:0] disp_dp_q;
    logic                  pending_q;
    logic                  wrapped_q;
    seg_t                  seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  frame_q;

    logic                  tick_c;
    logic                  wrap_c;
    logic [NUM_DIGITS-1:0] blank_c;
    logic                  lz_run_c;
    bcd_t                  cur_code_c;
    logic                  cur_blank_c;
    logic                  cur_dp_c;
    logic [NUM_DIGITS-1:0] an_hot_c;
    seg_t                  seg_c;

    assign tick_c = (pre_q == PRE_LAST);
    assign wrap_c = tick_c && (idx_q == IDX_LAST);

    // Prescaler and digit index
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (tick_c) begin
            pre_q <= '0;
            idx_q <= wrap_c ? '0 : idx_q + IDX_W'(1);
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    // Shadow capture and frame-boundary commit; a Load on the wrap cycle bypasses the shadow
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            disp_bcd_q   <= '0;
            disp_dp_q    <= '0;
            pending_q    <= 1'b0;
        end else begin
            if (bus.Load) begin
                shadow_bcd_q <= bus.Bcd;
                shadow_dp_q  <= bus.Dp_In;
            end
            if (wrap_c) begin
                if (bus.Load) begin
                    disp_bcd_q <= bus.Bcd;
                    disp_dp_q  <= bus.Dp_In;
                    pending_q  <= 1'b0;
                end else if (pending_q) begin
                    disp_bcd_q <= shadow_bcd_q;
                    disp_dp_q  <= shadow_dp_q;
                    pending_q  <= 1'b0;
                end
            end else if (bus.Load) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Leading-zero chain: a digit blanks when it and all more-significant digits are zero
    always_comb begin
        blank_c  = '0;
        lz_run_c = bus.Blank_Lz;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run_c = lz_run_c && (disp_bcd_q[i*BCD_W +: BCD_W] == '0);
            if (i != 0) begin
                blank_c[i] = lz_run_c;
            end
        end
    end

    // Select the active digit's code, blank, dp and enable
    always_comb begin
        cur_code_c  = '0;
        cur_blank_c = 1'b0;
        cur_dp_c    = 1'b0;
        an_hot_c    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_code_c  = disp_bcd_q[i*BCD_W +: BCD_W];
                cur_blank_c = blank_c[i];
                cur_dp_c    = disp_dp_q[i];
                an_hot_c[i] = 1'b1;
            end
        end
    end

    bcd_seg_decode u_decode (
        .code  (cur_code_c),
        .blank (cur_blank_c),
        .seg_c (seg_c)
    );

    // Output registers with polarity applied; Frame lags the wrap by one cycle to line up with An
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            seg_q     <= SEG_INV;
            dp_q      <= DP_INV;
            an_q      <= AN_INV;
            wrapped_q <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            seg_q     <= seg_c ^ SEG_INV;
            dp_q      <= cur_dp_c ^ DP_INV;
            an_q      <= an_hot_c ^ AN_INV;
            wrapped_q <= wrap_c;
            frame_q   <= wrapped_q;
        end
    end

    assign bus.Seg    = seg_q;
    assign bus.Dp_Out = dp_q;
    assign bus.An     = an_q;
    assign bus.Frame  = frame_q;

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Multiplexed 7-segment display driver for the BCD counter chain. It accepts NUM_DIGITS packed BCD digits via a load strobe and time-multiplexes them onto one shared segment bus with per-digit enables. It applies leading-zero blanking and commits new values only at frame boundaries, so a counter update never tears a frame. It sits between the BCD counters and the board's common-anode display pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (2..8)
- SCAN_DIV, 100000, Clk cycles per digit slot (≥2)
- ACTIVE_LOW, 1, 1: Seg/Dp_Out/An asserted low; 0: asserted high
- Clk  in  1  system clock; all logic on posedge
- Rst  in  1  reset, asynchronous, active-high
- Load  in  1  one-cycle strobe; captures Bcd and Dp_In
- Bcd  in  4*NUM_DIGITS  packed digits; digit 0 (least significant) in [3:0]
- Dp_In  in  NUM_DIGITS  decimal point per digit, captured with Bcd
- Blank_Lz  in  1  leading-zero blanking enable; sampled live, not latched
- Seg  out  7  segments a..g on Seg[0]..Seg[6]
- Dp_Out  out  1  decimal point of the active digit
- An  out  NUM_DIGITS  digit enables, one-hot when active
- Frame  out  1  one-cycle pulse when digit 0 becomes active

## Operation
- Registers: prescaler (0..SCAN_DIV-1), digit index (0..NUM_DIGITS-1), shadow {Bcd, Dp}, display {Bcd, Dp}, pending flag, registered outputs.
- Prescaler increments every cycle. At terminal count it returns to 0 and the index advances. The index wraps from NUM_DIGITS-1 to 0.
- Load writes shadow and sets pending. A later Load before commit overwrites the shadow (last value wins).
- Commit occurs on the cycle the index wraps to 0 while pending=1: display ← shadow and pending clears.
- If Load coincides with a wrap, the incoming Bcd/Dp_In is committed directly (bypass) and pending stays 0.
- Decode per digit: codes 0–9 give the standard glyphs. Codes 10–15 give a dash (g only). Blanked digits give all segments off.
- Leading-zero blanking: when Blank_Lz=1, a digit is blanked if it and every more-significant digit equal 0. Digit 0 is never blanked. Dp_Out is unaffected by blanking.
- Polarity: when ACTIVE_LOW=1, Seg, Dp_Out and An are inverted at the output registers.

## Timing
- Reset values: prescaler 0, index 0, shadow 0, display 0, pending 0, Frame 0; An, Seg and Dp_Out all in the inactive level.
- Outputs are registered, with one cycle of latency from the index/display state. The first cycle after Rst deasserts drives digit 0; Frame stays 0 on that cycle.
- Each digit is active for exactly SCAN_DIV cycles, and a frame lasts NUM_DIGITS·SCAN_DIV cycles.
- Frame is high on the first cycle An selects digit 0 in every frame after the first.
- From a Load to a visible update: at most one frame plus one cycle.
- Reset asserted mid-frame forces all outputs inactive immediately (asynchronous) and discards both pending and shadow data.
- Bcd and Dp_In are ignored when Load=0.

## Structure
- Package bcd_disp_pkg: 7-bit segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK, and the segment bit-order definition.
- Sub-module bcd_seg_decode: combinational 4-bit code + blank → 7-bit active-high segments.
- The top level holds the prescaler, index, shadow/commit logic, blanking chain and polarity output registers.

## Test plan
Run with SCAN_DIV=4, NUM_DIGITS=4, ACTIVE_LOW=1.
- Reset release, then Load Bcd=16'h1234 → from the second frame, An cycles 1110, 1101, 1011, 0111 (4 cycles each). Seg shows 4, 3, 2, 1 (SEG_4 inverted, …). Frame pulses every 16 cycles.
- Load 16'h0007 with Blank_Lz=1 → digits 3..1 blank (Seg=7'h7F) and digit 0 shows 7. With Blank_Lz=0 the display shows 0007; Load 16'h0000 with Blank_Lz=1 → only digit 0 lit, showing 0.
- Load 16'h12A4 → digit 1 shows the dash (Seg=~7'b1000000); the other digits are unchanged.
- Load 16'h1111 mid-frame, then 16'h2222 before the wrap → the next frame shows 2222 only, and 1111 never appears. Load 16'h3333 on the wrap cycle → 3333 appears in that same frame.
- Load with Dp_In=4'b0100 → Dp_Out active only while An selects digit 2, including when that digit is blanked.
- Assert Rst for 3 cycles in the middle of digit 2's slot → An=4'hF and Seg=7'h7F during reset. After release, digit 0 shows 0 and a previously pending Load is not shown.
